// File: rtl/change_pkg.sv
// Shared types for the change dispenser: FSM states and coin selector encodings.
package change_pkg;

  localparam int unsigned COIN_SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    DISPENSE = 2'd2,
    FIN      = 2'd3
  } state_e;

  typedef enum logic [COIN_SEL_W-1:0] {
    COIN_UNIT = 2'd0,
    COIN_B    = 2'd1,
    COIN_A    = 2'd2
  } coin_sel_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Request/result and coin-hopper handshake bundle between the vending FSM, dispenser and hopper.
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 8
);
  import change_pkg::*;

  logic                  calculate;
  logic [AMT_W-1:0]      paid;
  logic [AMT_W-1:0]      price;
  logic [AMT_W-1:0]      change;
  logic                  busy;
  logic                  coin_valid;
  logic [COIN_SEL_W-1:0] coin_sel;
  logic                  coin_ready;
  logic                  done;
  logic                  error;

  modport master (
    output calculate, paid, price, coin_ready,
    input  change, busy, coin_valid, coin_sel, done, error
  );

  modport slave (
    input  calculate, paid, price, coin_ready,
    output change, busy, coin_valid, coin_sel, done, error
  );

endinterface

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination not exceeding the remaining amount.
module coin_select
  import change_pkg::*;
#(
  parameter int unsigned AMT_W   = 8,
  parameter int unsigned DENOM_A = 10,
  parameter int unsigned DENOM_B = 5
) (
  input  logic [AMT_W-1:0] remaining_i,
  output coin_sel_e        coin_sel_o,
  output logic [AMT_W-1:0] coin_val_o
);

  always_comb begin
    coin_sel_o = COIN_UNIT;
    coin_val_o = AMT_W'(1);
    if (remaining_i >= AMT_W'(DENOM_A)) begin
      coin_sel_o = COIN_A;
      coin_val_o = AMT_W'(DENOM_A);
    end else if (remaining_i >= AMT_W'(DENOM_B)) begin
      coin_sel_o = COIN_B;
      coin_val_o = AMT_W'(DENOM_B);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Latches paid/price, computes change, then hands it out one greedy coin per valid/ready handshake.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned AMT_W   = 8,
  parameter int unsigned DENOM_A = 10,
  parameter int unsigned DENOM_B = 5
) (
  input  logic                clk,
  input  logic                rst,
  change_dispenser_if.slave   bus
);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] paid_q, paid_d;
  logic [AMT_W-1:0] price_q, price_d;
  logic [AMT_W-1:0] change_q, change_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic             err_q, err_d;

  coin_sel_e        sel;
  logic [AMT_W-1:0] coin_val;

  coin_select #(
    .AMT_W   (AMT_W),
    .DENOM_A (DENOM_A),
    .DENOM_B (DENOM_B)
  ) u_coin_select (
    .remaining_i (remaining_q),
    .coin_sel_o  (sel),
    .coin_val_o  (coin_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      paid_q      <= '0;
      price_q     <= '0;
      change_q    <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      paid_q      <= paid_d;
      price_q     <= price_d;
      change_q    <= change_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    paid_d      = paid_q;
    price_d     = price_q;
    change_d    = change_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.calculate) begin
          paid_d  = bus.paid;
          price_d = bus.price;
          state_d = CALC;
        end
      end
      CALC: begin
        if (paid_q < price_q) begin
          change_d = '0;
          err_d    = 1'b1;
          state_d  = FIN;
        end else if (paid_q == price_q) begin
          change_d = '0;
          state_d  = FIN;
        end else begin
          change_d    = paid_q - price_q;
          remaining_d = paid_q - price_q;
          state_d     = DISPENSE;
        end
      end
      DISPENSE: begin
        // coin_valid is implied by the state, so ready alone completes the handshake
        if (bus.coin_ready) begin
          remaining_d = remaining_q - coin_val;
          if (remaining_d == '0) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no path from coin_ready.
  assign bus.change     = change_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.coin_valid = (state_q == DISPENSE);
  assign bus.coin_sel   = sel;
  assign bus.done       = (state_q == FIN);
  assign bus.error      = (state_q == FIN) && err_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench: table of transactions plus stall, mid-dispense calculate and reset-abort sequences.
module tb_change_dispenser;

  localparam int unsigned AMT_W = 8;

  typedef struct {
    logic [7:0]  paid;
    logic [7:0]  price;
    logic [7:0]  chg;
    bit          err;
    int          n;
    logic [15:0] seq;   // coin i in bits [2i+1:2i]
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  change_dispenser_if #(.AMT_W(AMT_W)) bus ();

  change_dispenser #(
    .AMT_W   (AMT_W),
    .DENOM_A (10),
    .DENOM_B (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  vec_t       vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input int n, input logic [15:0] seq);
    for (int i = 0; i < n; i++) exp_q.push_back(seq[2*i +: 2]);
  endtask

  // Drive one request and follow it to done (or to a reset abort after abort_after coins).
  task automatic run_txn(input logic [7:0] p, input logic [7:0] pr, input logic [7:0] ch,
                         input bit er, input int ncoins, input int stall,
                         input bit mid_calc, input int abort_after);
    int cyc = 0;
    int dcnt = 0;
    int hs = 0;
    bit hs_pending = 0;
    bit prev_valid = 0;
    bit seen_done = 0;
    logic [1:0] prev_sel = 2'd0;
    bus.paid       = p;
    bus.price      = pr;
    bus.calculate  = 1'b1;
    bus.coin_ready = (stall == 0);
    @(posedge clk); #1;
    bus.calculate = 1'b0;
    chk("busy_in_calc", int'(bus.busy), 1);
    while (!seen_done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      bus.calculate = 1'b0;
      if (abort_after > 0 && hs >= abort_after) begin
        chk("valid_before_abort", int'(bus.coin_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", int'(bus.coin_valid), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_change", int'(bus.change), 0);
        @(posedge clk); #1;
        chk("abort_done_held", int'(bus.done), 0);
        rst = 1'b0;
        exp_q.delete();
        bus.coin_ready = 1'b1;
        return;
      end
      if (bus.done) begin
        seen_done = 1;
        chk("change", int'(bus.change), int'(ch));
        chk("error", int'(bus.error), int'(er));
        chk("valid_in_done", int'(bus.coin_valid), 0);
        chk("coins_left", exp_q.size(), 0);
        chk("hs_count", hs, ncoins);
        if (ncoins > 0) chk("done_after_last_hs", int'(hs_pending), 1);
        else            chk("done_latency", cyc, 1);
      end else if (bus.coin_valid) begin
        chk("coin_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("coin_sel", int'(bus.coin_sel), int'(exp_q[0]));
        if (prev_valid && !hs_pending) chk("sel_stable", int'(bus.coin_sel), int'(prev_sel));
        bus.coin_ready = (dcnt >= stall);
        hs_pending = bus.coin_ready;
        if (hs_pending) begin
          hs++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (mid_calc && dcnt == 1) begin
          bus.calculate = 1'b1;
          bus.paid      = 8'd99;
        end
        prev_sel   = bus.coin_sel;
        prev_valid = 1;
        dcnt++;
      end else begin
        if (prev_valid && !hs_pending) chk("valid_stable", int'(bus.coin_valid), 1);
        hs_pending = 0;
        prev_valid = 0;
      end
    end
    chk("done_seen", int'(seen_done), 1);
    @(posedge clk); #1;
    chk("busy_after", int'(bus.busy), 0);
    chk("done_one_shot", int'(bus.done), 0);
    chk("change_held", int'(bus.change), int'(ch));
    bus.coin_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'd20,  8'd15,  8'd5,  1'b0, 1, 16'h0001};
    vecs[1] = '{8'd38,  8'd15,  8'd23, 1'b0, 5, 16'h000A};
    vecs[2] = '{8'd10,  8'd15,  8'd0,  1'b1, 0, 16'h0000};
    vecs[3] = '{8'd15,  8'd15,  8'd0,  1'b0, 0, 16'h0000};
    vecs[4] = '{8'd27,  8'd0,   8'd27, 1'b0, 5, 16'h001A};
    vecs[5] = '{8'd9,   8'd0,   8'd9,  1'b0, 5, 16'h0001};
    vecs[6] = '{8'd0,   8'd1,   8'd0,  1'b1, 0, 16'h0000};
    vecs[7] = '{8'd255, 8'd254, 8'd1,  1'b0, 1, 16'h0000};

    rst            = 1'b1;
    bus.calculate  = 1'b0;
    bus.paid       = '0;
    bus.price      = '0;
    bus.coin_ready = 1'b1;
    #1;
    chk("rst_busy",   int'(bus.busy), 0);
    chk("rst_valid",  int'(bus.coin_valid), 0);
    chk("rst_sel",    int'(bus.coin_sel), 0);
    chk("rst_done",   int'(bus.done), 0);
    chk("rst_error",  int'(bus.error), 0);
    chk("rst_change", int'(bus.change), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      push_seq(vecs[i].n, vecs[i].seq);
      run_txn(vecs[i].paid, vecs[i].price, vecs[i].chg, vecs[i].err, vecs[i].n, 0, 1'b0, 0);
    end

    // 30-15: hopper stalls three cycles, calculate pulsed mid-dispense
    push_seq(2, 16'h0006);
    run_txn(8'd30, 8'd15, 8'd15, 1'b0, 2, 3, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1 chk("no_requeue_busy", int'(bus.busy), 0);

    // 40-5: reset after the first coin, then a clean transaction
    push_seq(4, 16'h006A);
    run_txn(8'd40, 8'd5, 8'd35, 1'b0, 4, 0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_abort_done", int'(bus.done), 0);
    end
    push_seq(1, 16'h0001);
    run_txn(8'd20, 8'd15, 8'd5, 1'b0, 1, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Parametrised successor to the single-shot change calculator. It latches a paid/price pair and computes the change. It then dispenses that change as a greedy sequence of coins, one coin per valid/ready handshake, and flags insufficient payment. It sits between the vending FSM (which issues calculate) and the coin-hopper driver (which consumes coins).

Parameters:
AMT_W, 8, width of paid, price, change and the internal remaining register
DENOM_A, 10, value of the largest coin; must satisfy DENOM_A > DENOM_B
DENOM_B, 5, value of the middle coin; must satisfy DENOM_B > 1 (the smallest coin is always 1, which guarantees termination)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
calculate  in  1  start request; sampled only in IDLE
paid  in  AMT_W  amount inserted; latched with calculate
price  in  AMT_W  item price; latched with calculate
change  out  AMT_W  paid-price, registered; 0 on error
busy  out  1  high in every state except IDLE
coin_valid  out  1  a coin request is presented
coin_sel  out  2  2=DENOM_A, 1=DENOM_B, 0=unit coin; meaningful only while coin_valid
coin_ready  in  1  hopper accepts the current coin
done  out  1  one-cycle pulse at the end of a transaction
error  out  1  one-cycle pulse coincident with done when paid<price

Behaviour:
- Reset, asynchronous: state=IDLE; change, remaining, coin_valid, coin_sel, done and error all 0; busy=0.
- States: IDLE, CALC, DISPENSE, FIN.
- IDLE:
  - calculate=1 at edge N latches paid and price, then moves to CALC.
  - calculate is ignored in every other state; no queuing.
- CALC, one cycle, at edge N+1:
  - paid<price: change=0, error flag set, go to FIN.
  - paid==price: change=0, go to FIN with no coins.
  - Otherwise: change=remaining=paid-price at full AMT_W unsigned width (no wrap possible), go to DISPENSE.
- DISPENSE:
  - coin_valid=1.
  - coin_sel is the greedy pick: 2 if remaining>=DENOM_A, else 1 if remaining>=DENOM_B, else 0.
  - On coin_valid&&coin_ready: remaining -= the selected value.
  - If the new remaining is 0, go to FIN; otherwise stay.
  - While coin_ready=0, coin_valid and coin_sel are held stable.
  - At most one coin is accepted per cycle.
- FIN, one cycle: done=1, error=1 if the flag is set. Then go to IDLE and clear the flag.
- change holds its value until the next CALC, so it remains readable in IDLE.
- Latency:
  - Exact payment: done is high in the cycle after edge N+1.
  - Normal: first coin_valid appears after edge N+1; done follows one cycle after the final handshake.
- calculate asserted in FIN is ignored. A new request is accepted only once the FSM is back in IDLE.
- Reset mid-DISPENSE aborts immediately: coin_valid drops asynchronously and no done is issued.
- Outputs coin_valid, coin_sel, done and error are driven from registers or from a decode of state/remaining only. No combinational path from coin_ready to coin_valid.

Decomposition:
- Package change_pkg holds:
  - the state enum (IDLE, CALC, DISPENSE, FIN);
  - the coin_sel encodings (COIN_A=2, COIN_B=1, COIN_UNIT=0).
- Sub-module coin_select: combinational greedy selector.
  - Inputs: remaining.
  - Outputs: coin_sel and the coin value.
  - Parametrised by AMT_W, DENOM_A and DENOM_B.
  - Reusable by the refund path.

Test Plan:
1. Defaults; reset, then paid=20, price=15, calculate pulse, coin_ready=1 -> change=5; exactly one coin, coin_sel=1; done one cycle later; error=0.
2. paid=38, price=15 -> change=23; coin sequence 2,2,0,0,0 (five handshakes); single done pulse; busy low afterwards.
3. paid=10, price=15 -> change=0; no coin_valid ever; done=1 and error=1 in the same cycle, two cycles after calculate.
4. paid=15, price=15 -> change=0; no coins; done=1, error=0.
5. paid=30, price=15, coin_ready held low for 3 cycles -> coin_valid=1 and coin_sel=2 stable throughout; then the sequence 2,1; calculate pulsed mid-dispense has no effect.
6. paid=40, price=5; assert rst after the first coin handshake -> all outputs 0 immediately, no done; a following transaction with paid=20, price=15 completes normally.
